reg_skid_rst_y_mode_s: RTL and testbench



---
 rtl/reg_pkg.sv | 13 +
 rtl/reg_rst_y_mode_s_en_y.sv | 26 ++
 rtl/reg_skid_rst_y_mode_s.sv | 114 +++++++++++
 tb/tb_reg_skid_rst_y_mode_s.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared types and constants for the base register library.
// Holds the skid-buffer state encoding and the default payload width.
package reg_pkg;

    localparam int REG_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_BUSY,
        SKID_FULL
    } skid_state_e;

endpackage

// File: rtl/reg_rst_y_mode_s_en_y.sv
// Enable register with synchronous active-low reset to RST_VAL.
// Ports: i_clk, i_rst_n, i_en (load strobe), i_d (next value), o_q (stored value).
module reg_rst_y_mode_s_en_y #(
    parameter int              WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/reg_skid_rst_y_mode_s.sv
// Two-entry skid register: valid/ready on both sides, registered ready/valid.
// Ports: i_clk, i_rst_n (sync, active-low); upstream i_valid/o_ready/i_data;
// downstream o_valid/i_ready/o_data (o_data comes straight from the main reg).
module reg_skid_rst_y_mode_s
    import reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = REG_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RST_VAL    = {DATA_WIDTH{1'b0}}
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data
);

    skid_state_e            r_state;
    skid_state_e            w_state_nxt;
    logic                   r_valid;
    logic                   r_ready;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_load_main;
    logic                   w_load_skid;
    logic                   w_sel_skid;
    logic [DATA_WIDTH-1:0]  w_main_d;
    logic [DATA_WIDTH-1:0]  w_main_q;
    logic [DATA_WIDTH-1:0]  w_skid_q;

    // Handshakes use the registered flags, so i_ready never reaches o_ready
    // combinationally.
    assign w_in_fire  = i_valid & r_ready;
    assign w_out_fire = r_valid & i_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load_main = 1'b0;
        w_load_skid = 1'b0;
        w_sel_skid  = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main = 1'b1;
                    w_state_nxt = SKID_BUSY;
                end
            end
            SKID_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = SKID_FULL;
                end else if (w_out_fire) begin
                    w_state_nxt = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (w_out_fire) begin
                    w_load_main = 1'b1;
                    w_sel_skid  = 1'b1;
                    w_state_nxt = SKID_BUSY;
                end
            end
            default: begin
                // Unused encoding: drop back to a known-empty buffer.
                w_state_nxt = SKID_EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= SKID_EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= (w_state_nxt != SKID_EMPTY);
            r_ready <= (w_state_nxt != SKID_FULL);
        end
    end

    assign w_main_d = w_sel_skid ? w_skid_q : i_data;

    reg_rst_y_mode_s_en_y #(
        .WIDTH   (DATA_WIDTH),
        .RST_VAL (RST_VAL)
    ) u_main (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_load_main),
        .i_d     (w_main_d),
        .o_q     (w_main_q)
    );

    reg_rst_y_mode_s_en_y #(
        .WIDTH   (DATA_WIDTH),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_load_skid),
        .i_d     (i_data),
        .o_q     (w_skid_q)
    );

    assign o_valid = r_valid;
    assign o_ready = r_ready;
    assign o_data  = w_main_q;

endmodule

// File: tb/tb_reg_skid_rst_y_mode_s.sv
// Scoreboard bench for reg_skid_rst_y_mode_s.
// A queue-depth model predicts o_valid/o_ready; a queue predicts o_data.
module tb_reg_skid_rst_y_mode_s;

    localparam int          DW  = 32;
    localparam logic [31:0] RST = 32'hDEAD_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;

    int            n_tests = 0;
    int            n_fail  = 0;

    logic [31:0]   sb_q[$];
    int            m_cnt   = 0;
    logic          m_rdy   = 1'b0;
    logic          m_vld   = 1'b0;
    logic          last_in = 1'b0;
    int            n_out   = 0;

    always #5 clk = ~clk;

    reg_skid_rst_y_mode_s #(
        .DATA_WIDTH (DW),
        .RST_VAL    (RST)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Compare outputs mid-cycle, then advance the model across the edge.
    task automatic tick();
        logic in_f;
        logic out_f;
        @(negedge clk);
        check("o_valid", {31'd0, o_valid}, {31'd0, m_vld});
        check("o_ready", {31'd0, o_ready}, {31'd0, m_rdy});
        if (m_vld && sb_q.size() > 0) begin
            check("o_data", o_data, sb_q[0]);
        end
        last_in = 1'b0;
        if (!rst_n) begin
            sb_q.delete();
            m_cnt = 0;
        end else begin
            in_f  = i_valid & m_rdy;
            out_f = m_vld & i_ready;
            if (out_f) begin
                void'(sb_q.pop_front());
                n_out++;
            end
            if (in_f) sb_q.push_back(i_data);
            m_cnt   = m_cnt + int'(in_f) - int'(out_f);
            last_in = in_f;
        end
        m_vld = rst_n && (m_cnt != 0);
        m_rdy = rst_n && (m_cnt != 2);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        int t;
        i_valid = 1'b1;
        i_data  = d;
        t = 0;
        do begin
            tick();
            t++;
        end while (!last_in && t < 20);
        if (!last_in) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t;
        i_valid = 1'b0;
        i_ready = 1'b1;
        t = 0;
        while ((m_cnt != 0) && t < 20) begin
            tick();
            t++;
        end
        tick();
        check("drain_empty", m_cnt, 32'd0);
    endtask

    initial begin
        logic [31:0] pat;
        int          t;
        int          target;
        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_data  = 32'h1234_5678;
        @(posedge clk);
        #1;

        // 1: reset held, inputs ignored, then release
        repeat (3) tick();
        check("rst_data", o_data, RST);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        tick();
        check("rel_ready", {31'd0, o_ready}, 32'd1);
        check("rel_data", o_data, RST);

        // 2: back-to-back with downstream ready
        i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) push(32'hA000_0000 + k);
        drain();

        // 3: back-pressure fills both entries
        i_ready = 1'b0;
        push(32'h0000_00B1);
        push(32'h0000_00B2);
        i_data = 32'h0000_00B3;
        repeat (5) begin
            tick();
            check("b3_blocked", {31'd0, last_in}, 32'd0);
            check("stall_data", o_data, 32'h0000_00B1);
        end

        // 4: release back-pressure
        i_ready = 1'b1;
        push(32'h0000_00B3);
        drain();

        // 5: random handshakes, incrementing payload
        pat    = 32'h0001_0000;
        target = n_out + 1000;
        t      = 0;
        while (n_out < target && t < 20000) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = 1'($urandom_range(0, 1));
            i_data  = pat;
            tick();
            if (last_in) pat++;
            t++;
        end
        check("rand_beats", n_out, target);
        drain();

        // 6: reset while full discards both entries
        i_ready = 1'b0;
        push(32'h0000_00C1);
        push(32'h0000_00C2);
        i_valid = 1'b0;
        rst_n   = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_vld", {31'd0, o_valid}, 32'd0);
        tick();
        push(32'h0000_00D1);
        push(32'h0000_00D2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
